// File: rtl/unidad_control_pkg.sv
// Shared opcode/state enums, datapath encodings and the control-word struct
// used by the unidad_control slice.
package unidad_control_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0, OP_MOV = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
    OP_AND  = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_NOT = 4'h7,
    OP_SHL  = 4'h8, OP_SHR = 4'h9, OP_LDI = 4'hA, OP_LD  = 4'hB,
    OP_ST   = 4'hC, OP_BRZ = 4'hD, OP_BRN = 4'hE, OP_HALT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    S_FETCH, S_LOAD, S_EXEC, S_MEMW, S_HALT
  } state_t;

  localparam logic [3:0] G_A   = 4'b0000;
  localparam logic [3:0] G_ADD = 4'b0010;
  localparam logic [3:0] G_SUB = 4'b0101;
  localparam logic [3:0] G_AND = 4'b1000;
  localparam logic [3:0] G_OR  = 4'b1001;
  localparam logic [3:0] G_XOR = 4'b1010;
  localparam logic [3:0] G_NOT = 4'b1011;

  localparam logic [1:0] H_B   = 2'b00;
  localparam logic [1:0] H_SHR = 2'b01;
  localparam logic [1:0] H_SHL = 2'b10;

  localparam int OP_LSB  = 12;
  localparam int DR_LSB  = 10;
  localparam int SA_LSB  = 8;
  localparam int SB_LSB  = 6;
  localparam int IMM_LSB = 0;

  typedef struct packed {
    logic       instr_rd;
    logic [1:0] a_sel;
    logic [1:0] b_sel;
    logic [1:0] dest_sel;
    logic [1:0] h_sel;
    logic [3:0] g_sel;
    logic       mb_sel;
    logic       md_sel;
    logic       mf_sel;
    logic       load_en;
    logic       mem_rd;
    logic       mem_wr;
    logic [7:0] cons;
  } ctrl_word_t;

endpackage

// File: rtl/unidad_control_ctrl_word_decode.sv
// Combinational decode of FSM state + IR into the datapath control word.
// Honours UNIDAD_CONTROL_BRANCH_EN for the BRZ/BRN operand select.
module ctrl_word_decode
  import unidad_control_pkg::*;
(
  input  state_t          state,
  input  logic [15:0]     ir,
  output ctrl_word_t      cw
);

  opcode_t    op;
  logic [1:0] dr, sa, sb;

  assign op = opcode_t'(ir[OP_LSB +: 4]);
  assign dr = ir[DR_LSB +: 2];
  assign sa = ir[SA_LSB +: 2];
  assign sb = ir[SB_LSB +: 2];

  always_comb begin
    cw = '0;
    case (state)
      S_FETCH: cw.instr_rd = 1'b1;
      S_EXEC: begin
        case (op)
          OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT: begin
            cw.a_sel    = sa;
            cw.load_en  = 1'b1;
            cw.dest_sel = dr;
            if (op != OP_MOV && op != OP_NOT) cw.b_sel = sb;
            case (op)
              OP_ADD:  cw.g_sel = G_ADD;
              OP_SUB:  cw.g_sel = G_SUB;
              OP_AND:  cw.g_sel = G_AND;
              OP_OR:   cw.g_sel = G_OR;
              OP_XOR:  cw.g_sel = G_XOR;
              OP_NOT:  cw.g_sel = G_NOT;
              default: cw.g_sel = G_A;
            endcase
          end
          OP_SHL, OP_SHR: begin
            cw.b_sel    = sb;
            cw.mf_sel   = 1'b1;
            cw.h_sel    = (op == OP_SHL) ? H_SHL : H_SHR;
            cw.load_en  = 1'b1;
            cw.dest_sel = dr;
          end
          OP_LDI: begin
            // immediate enters on the B bus and passes the shifter unshifted
            cw.mb_sel   = 1'b1;
            cw.mf_sel   = 1'b1;
            cw.h_sel    = H_B;
            cw.cons     = ir[IMM_LSB +: 8];
            cw.load_en  = 1'b1;
            cw.dest_sel = dr;
          end
          OP_LD: begin
            cw.mem_rd = 1'b1;
            cw.a_sel  = sa;
          end
          OP_ST: begin
            cw.mem_wr = 1'b1;
            cw.a_sel  = sa;
            cw.b_sel  = sb;
          end
`ifdef UNIDAD_CONTROL_BRANCH_EN
          OP_BRZ, OP_BRN: begin
            cw.a_sel = sa;
            cw.g_sel = G_A;
          end
`endif
          default: ;
        endcase
      end
      S_MEMW: begin
        cw.md_sel   = 1'b1;
        cw.load_en  = 1'b1;
        cw.dest_sel = dr;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/unidad_control.sv
// Hardwired FETCH/LOAD/EXEC(/MEMW) sequencer for the 4-register Procesador.
// Define UNIDAD_CONTROL_BRANCH_EN to enable BRZ/BRN; otherwise they act as NOP.
module unidad_control
  import unidad_control_pkg::*;
#(
  parameter int m = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic [m-1:0] instr_addr,
  output logic         instr_rd,
  input  logic [15:0]  instr_data,
  input  logic [3:0]   Tags,
  output logic [1:0]   A_sel,
  output logic [1:0]   B_sel,
  output logic [1:0]   Dest_sel,
  output logic [1:0]   H_sel,
  output logic [3:0]   G_sel,
  output logic         MB_sel,
  output logic         MD_sel,
  output logic         MF_sel,
  output logic         Load_en,
  output logic [m-1:0] Cons_IN,
  output logic         mem_rd,
  output logic         mem_wr,
  output logic         halted
);

  state_t       state_q, state_d;
  logic [m-1:0] pc_q, pc_d;
  logic [15:0]  ir_q, ir_d;
  opcode_t      op;
  ctrl_word_t   cw;
  logic         br_take;
  logic [m-1:0] br_off;
  logic         unused_tags;

  assign op = opcode_t'(ir_q[OP_LSB +: 4]);

`ifdef UNIDAD_CONTROL_BRANCH_EN
  assign br_take     = (op == OP_BRZ && Tags[0]) || (op == OP_BRN && Tags[1]);
  assign br_off      = {{(m-6){ir_q[5]}}, ir_q[5:0]};
  assign unused_tags = ^Tags[3:2];
`else
  assign br_take     = 1'b0;
  assign br_off      = '0;
  assign unused_tags = ^Tags;
`endif

  ctrl_word_decode u_dec (
    .state (state_q),
    .ir    (ir_q),
    .cw    (cw)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        ir_d    = instr_data;
        pc_d    = pc_q + m'(1);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        if (op == OP_LD)        state_d = S_MEMW;
        else if (op == OP_HALT) state_d = S_HALT;
        // PC already points past the branch, so the offset is relative to PC+1
        if (br_take) pc_d = pc_q + br_off;
      end
      S_MEMW:  state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // side-effecting strobes are gated so a reset mid-instruction never writes
  assign instr_rd   = cw.instr_rd & rst_n;
  assign Load_en    = cw.load_en  & rst_n;
  assign mem_rd     = cw.mem_rd   & rst_n;
  assign mem_wr     = cw.mem_wr   & rst_n;
  assign instr_addr = pc_q;
  assign A_sel      = cw.a_sel;
  assign B_sel      = cw.b_sel;
  assign Dest_sel   = cw.dest_sel;
  assign H_sel      = cw.h_sel;
  assign G_sel      = cw.g_sel;
  assign MB_sel     = cw.mb_sel;
  assign MD_sel     = cw.md_sel;
  assign MF_sel     = cw.mf_sel;
  assign Cons_IN    = m'(cw.cons);
  assign halted     = (state_q == S_HALT);

endmodule

// File: tb/tb_unidad_control.sv
// Bench for unidad_control: instruction-level reference model predicts every
// cycle's control outputs; random programs plus directed scenarios.
module tb_unidad_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  instr_addr;
  logic        instr_rd;
  logic [15:0] instr_data = 16'h0;
  logic [3:0]  Tags = 4'h0;
  logic [1:0]  A_sel, B_sel, Dest_sel, H_sel;
  logic [3:0]  G_sel;
  logic        MB_sel, MD_sel, MF_sel, Load_en;
  logic [7:0]  Cons_IN;
  logic        mem_rd, mem_wr, halted;

  unidad_control #(.m(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_addr(instr_addr), .instr_rd(instr_rd), .instr_data(instr_data),
    .Tags(Tags),
    .A_sel(A_sel), .B_sel(B_sel), .Dest_sel(Dest_sel), .H_sel(H_sel),
    .G_sel(G_sel), .MB_sel(MB_sel), .MD_sel(MD_sel), .MF_sel(MF_sel),
    .Load_en(Load_en), .Cons_IN(Cons_IN),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .halted(halted)
  );

  always #5 clk = ~clk;

  logic [15:0] imem [256];
  always @(posedge clk) if (instr_rd) instr_data <= imem[instr_addr];

  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  mpc;
  logic [35:0] obs;

  assign obs = {instr_rd, instr_addr, A_sel, B_sel, Dest_sel, H_sel, G_sel,
                MB_sel, MD_sel, MF_sel, Load_en, Cons_IN, mem_rd, mem_wr, halted};

  function automatic logic [35:0] mk(
    input logic ird, input logic [7:0] addr,
    input logic [1:0] a, input logic [1:0] b, input logic [1:0] d, input logic [1:0] h,
    input logic [3:0] g, input logic mb, input logic md, input logic mf, input logic ld,
    input logic [7:0] cons, input logic mr, input logic mw, input logic hl);
    return {ird, addr, a, b, d, h, g, mb, md, mf, ld, cons, mr, mw, hl};
  endfunction

  function automatic logic [35:0] idle(input logic [7:0] addr, input logic ird, input logic hl);
    return mk(ird, addr, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, hl);
  endfunction

  // ISA table: what the datapath must see while an instruction executes
  function automatic logic [35:0] exec_exp(input logic [15:0] ins, input logic [7:0] addr);
    logic [1:0] a, b, d, h, sa, sb;
    logic [3:0] g;
    logic       mb, mf, ld, mr, mw;
    logic [7:0] cons;
    {a, b, d, h, g, mb, mf, ld, mr, mw, cons} = '0;
    sa = ins[9:8];
    sb = ins[7:6];
    case (ins[15:12])
      4'h1: begin a = sa; ld = 1'b1; end
      4'h2: begin a = sa; b = sb; g = 4'b0010; ld = 1'b1; end
      4'h3: begin a = sa; b = sb; g = 4'b0101; ld = 1'b1; end
      4'h4: begin a = sa; b = sb; g = 4'b1000; ld = 1'b1; end
      4'h5: begin a = sa; b = sb; g = 4'b1001; ld = 1'b1; end
      4'h6: begin a = sa; b = sb; g = 4'b1010; ld = 1'b1; end
      4'h7: begin a = sa; g = 4'b1011; ld = 1'b1; end
      4'h8: begin b = sb; h = 2'b10; mf = 1'b1; ld = 1'b1; end
      4'h9: begin b = sb; h = 2'b01; mf = 1'b1; ld = 1'b1; end
      4'hA: begin mb = 1'b1; mf = 1'b1; cons = ins[7:0]; ld = 1'b1; end
      4'hB: begin a = sa; mr = 1'b1; end
      4'hC: begin a = sa; b = sb; mw = 1'b1; end
`ifdef UNIDAD_CONTROL_BRANCH_EN
      4'hD, 4'hE: a = sa;
`endif
      default: ;
    endcase
    if (ld) d = ins[11:10];
    return mk(1'b0, addr, a, b, d, h, g, mb, 1'b0, mf, ld, cons, mr, mw, 1'b0);
  endfunction

  // Runs one instruction from the model PC; entered at a negedge in FETCH.
  task automatic step_instr(input logic [3:0] tags, input string nm);
    logic [15:0] ins;
    logic [7:0]  npc;
    logic [35:0] e;
    logic        take;
    ins  = imem[mpc];
    npc  = mpc + 8'd1;
    Tags = 4'($urandom);
    #1;
    e = idle(mpc, 1'b1, 1'b0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL %s fetch pc=%h: got %h want %h", nm, mpc, obs, e); end
    @(negedge clk); #1;
    e = idle(mpc, 1'b0, 1'b0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL %s load pc=%h: got %h want %h", nm, mpc, obs, e); end
    @(negedge clk);
    Tags = tags;
    #1;
    e = exec_exp(ins, npc);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL %s exec ins=%h: got %h want %h", nm, ins, obs, e); end
    if (ins[15:12] == 4'hB) begin
      @(negedge clk); #1;
      e = mk(1'b0, npc, 2'd0, 2'd0, ins[11:10], 2'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL %s memw ins=%h: got %h want %h", nm, ins, obs, e); end
    end
    @(negedge clk);
    take = 1'b0;
`ifdef UNIDAD_CONTROL_BRANCH_EN
    take = (ins[15:12] == 4'hD && tags[0]) || (ins[15:12] == 4'hE && tags[1]);
`endif
    mpc = take ? npc + {{2{ins[5]}}, ins[5:0]} : npc;
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (obs !== idle(8'd0, 1'b0, 1'b0)) begin
      miscompares++; $display("FAIL reset: got %h want %h", obs, idle(8'd0, 1'b0, 1'b0));
    end
    rst_n = 1'b1;
    mpc   = 8'd0;
  endtask

  task automatic test_alu_prog();
    fill_nop();
    imem[0] = {4'hA, 2'd1, 8'h05, 2'd0};
    imem[0] = {4'hA, 2'd1, 2'd0, 8'h05};
    imem[1] = {4'hA, 2'd2, 2'd0, 8'h03};
    imem[2] = {4'h2, 2'd3, 2'd1, 2'd2, 6'd0};
    imem[3] = {4'h8, 2'd0, 2'd0, 2'd3, 6'd0};
    imem[4] = {4'h7, 2'd2, 2'd3, 8'd0};
    test_reset();
    for (int i = 0; i < 5; i++) step_instr(4'h0, "alu_prog");
  endtask

  task automatic test_st_ld();
    fill_nop();
    imem[0] = {4'hC, 2'd0, 2'd1, 2'd2, 6'd0};
    imem[1] = {4'hB, 2'd0, 2'd1, 2'd0, 6'd0};
    imem[2] = {4'h9, 2'd1, 2'd0, 2'd3, 6'd0};
    test_reset();
    for (int i = 0; i < 3; i++) step_instr(4'h0, "st_ld");
  endtask

  task automatic test_branch();
    fill_nop();
    imem[8'h10] = {4'hD, 2'd0, 2'd0, 8'h3E};
    imem[8'h11] = {4'hE, 2'd0, 2'd1, 8'h03};
    test_reset();
    for (int i = 0; i < 16; i++) step_instr(4'h0, "branch_pre");
    step_instr(4'b0001, "brz_taken");
    step_instr(4'b1110, "branch_mid");
    step_instr(4'b0000, "brz_not_taken");
    step_instr(4'b0010, "brn");
    step_instr(4'b0000, "branch_post");
  endtask

  task automatic test_pc_wrap();
    fill_nop();
    test_reset();
    for (int i = 0; i < 258; i++) step_instr(4'($urandom), "pc_wrap");
  endtask

  task automatic test_reset_mid_exec();
    logic [35:0] e;
    fill_nop();
    imem[0] = {4'h2, 2'd3, 2'd1, 2'd2, 6'd0};
    test_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    e = mk(1'b0, 8'd1, 2'd1, 2'd2, 2'd3, 2'd0, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL rst_mid_exec: got %h want %h", obs, e); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    e = idle(8'd0, 1'b1, 1'b0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL rst_mid_exec refetch: got %h want %h", obs, e); end
    mpc = 8'd0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_halt();
    logic [35:0] e;
    fill_nop();
    imem[0] = {4'hA, 2'd0, 2'd0, 8'h7F};
    imem[1] = 16'hF000;
    imem[2] = {4'hA, 2'd1, 2'd0, 8'h11};
    test_reset();
    step_instr(4'h0, "halt_pre");
    step_instr(4'h0, "halt");
    for (int i = 0; i < 20; i++) begin
      #1;
      e = idle(8'd2, 1'b0, 1'b1);
      vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL halted cyc=%0d: got %h want %h", i, obs, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 256; i++) imem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
    test_reset();
    for (int i = 0; i < 200; i++) step_instr(4'($urandom), "random");
  endtask

  initial begin
    fill_nop();
    @(negedge clk);
    test_reset();
    test_alu_prog();
    test_st_ld();
    test_branch();
    test_pc_wrap();
    test_reset_mid_exec();
    test_halt();
    test_random();
    test_halt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
